mult_seq_ctrl: RTL and testbench

Counter-based sequencing controller for the 8-bit shift-add two's-complement multiplier datapath: A/B shift registers, X flip-flop and 9-bit adder/subtractor. It replaces the unrolled per-bit state chain with a compact FSM plus a bit counter, so the same block drives any operand width WIDTH. It also adds rising-edge start detection, plus Busy and Done status outputs for the top level and LEDs. It sits between the input synchronizers and the datapath load, shift and arithmetic enables.

---
 rtl/mult_seq_ctrl.sv | 63 ++++++
 tb/tb_mult_seq_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: counter-based sequencer for a WIDTH-bit shift-add two's-complement multiplier datapath
// Ports: Clk, Reset (sync, active-high); Run, ClearA_LoadB (synchronized requests); M (multiplier LSB B[0]);
//        Clr_Ld, Clr_XA, Add, Sub, Shift (datapath enables); Busy, Done (status)
module mult_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Clr_Ld,
   output logic Clr_XA,
   output logic Add,
   output logic Sub,
   output logic Shift,
   output logic Busy,
   output logic Done
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [2:0] {IDLE, CLEAR, CALC, SHIFT, HOLD} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic run_prev;
   logic start;
   logic last;
   // run_prev resets high so a Run held through reset never looks like a fresh press
   assign start = Run & ~run_prev;
   assign last  = cnt == LAST;
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         run_prev <= 1'b1;
      end else begin
         run_prev <= Run;
         case (state)
            IDLE:    if (!ClearA_LoadB && start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                     end
            CLEAR:   state <= CALC;
            CALC:    state <= SHIFT;
            SHIFT:   if (last) state <= HOLD;
                     else begin
                        cnt   <= cnt + CW'(1);
                        state <= CALC;
                     end
            HOLD:    if (!Run) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   // the final iteration weighs the sign bit negatively, hence Sub instead of Add
   assign Clr_Ld = state == IDLE && ClearA_LoadB;
   assign Clr_XA = state == CLEAR;
   assign Add    = state == CALC && M && !last;
   assign Sub    = state == CALC && M && last;
   assign Shift  = state == SHIFT;
   assign Busy   = state == CLEAR || state == CALC || state == SHIFT;
   assign Done   = state == HOLD;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: randomized self-checking bench with a behavioural datapath and timing model
module tb_mult_seq_ctrl;
   localparam int W = 8;
   logic Clk = 1'b0, Reset = 1'b1, Run = 1'b0, ClearA_LoadB = 1'b0, M;
   logic Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done;
   logic [7:0] sw = '0, s_reg = '0, a_dp = '0, b_dp = '0;
   logic x_dp = 1'b0;
   int tests = 0, fails = 0;

   always #5 Clk = ~Clk;

   mult_seq_ctrl #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
      .Clr_Ld(Clr_Ld), .Clr_XA(Clr_XA), .Add(Add), .Sub(Sub), .Shift(Shift),
      .Busy(Busy), .Done(Done)
   );

   assign M = b_dp[0];

   always @(posedge Clk) begin
      if (Clr_Ld) begin
         a_dp <= '0;
         x_dp <= 1'b0;
         b_dp <= sw;
      end else if (Clr_XA) begin
         a_dp <= '0;
         x_dp <= 1'b0;
      end else if (Add) {x_dp, a_dp} <= {a_dp[7], a_dp} + {s_reg[7], s_reg};
      else if (Sub) {x_dp, a_dp} <= {a_dp[7], a_dp} - {s_reg[7], s_reg};
      else if (Shift) begin
         a_dp <= {x_dp, a_dp[7:1]};
         b_dp <= {a_dp[0], b_dp[7:1]};
      end
   end

   function automatic logic [6:0] outs();
      return {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done};
   endfunction

   task automatic chk(input string name, input logic [6:0] exp);
      tests++;
      if (outs() !== exp) begin
         fails++;
         $display("FAIL %s: outputs got %b expected %b", name, outs(), exp);
      end
   endtask

   task automatic run_mult(input logic [7:0] s, input logic [7:0] b, input int hold,
                           input bit extra, input int abort_k);
      logic [6:0] exp;
      logic signed [15:0] prod;
      bit calc;
      int i;
      s_reg = s;
      sw = b;
      ClearA_LoadB = 1'b1;
      Run = 1'b0;
      @(negedge Clk);
      ClearA_LoadB = 1'b0;
      @(negedge Clk);
      Run = 1'b1;
      for (int k = 1; k <= 2 * W + 2; k++) begin
         @(negedge Clk);
         calc = k >= 2 && k <= 2 * W && k % 2 == 0;
         i = calc ? (k - 2) / 2 : 0;
         exp = {1'b0, k == 1, calc && b[i] && i < W - 1, calc && b[i] && i == W - 1,
                k >= 3 && k <= 2 * W + 1 && k % 2 == 1, k <= 2 * W + 1, k == 2 * W + 2};
         tests++;
         if (outs() !== exp) begin
            fails++;
            $display("FAIL seq s=%h b=%h k=%0d: outputs got %b expected %b", s, b, k, outs(), exp);
         end
         if (k == abort_k) begin
            Reset = 1'b1;
            @(negedge Clk);
            chk("abort_reset", 7'b0);
            Reset = 1'b0;
            Run = 1'b0;
            return;
         end
         if (extra && k == 4) Run = 1'b0;
         if (extra && k == 6) Run = 1'b1;
      end
      prod = $signed(s) * $signed(b);
      tests++;
      if ({a_dp, b_dp} !== prod) begin
         fails++;
         $display("FAIL product %h*%h: A:B got %h expected %h", s, b, {a_dp, b_dp}, prod);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge Clk);
         chk("hold_done", 7'b0000001);
      end
      Run = 1'b0;
      @(negedge Clk);
      chk("hold_exit", 7'b0);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      Run = 1'b1;
      repeat (3) @(negedge Clk);
      chk("reset_state", 7'b0);
      Reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         chk("reset_run_held", 7'b0);
      end
      Run = 1'b0;
      @(negedge Clk);
      chk("reset_run_low", 7'b0);
      Run = 1'b1;
      @(negedge Clk);
      chk("reset_fresh_start", 7'b0100010);
      Reset = 1'b1;
      @(negedge Clk);
      chk("reset_from_clear", 7'b0);
      Reset = 1'b0;
      Run = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_clear_load();
      ClearA_LoadB = 1'b1;
      for (int c = 0; c < 3; c++) begin
         Run = c[0];
         @(negedge Clk);
         chk("clear_load_active", 7'b1000000);
      end
      ClearA_LoadB = 1'b0;
      Run = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge Clk);
         chk("clear_load_idle", 7'b0);
      end
   endtask

   task automatic test_multiply();
      run_mult(8'($urandom), 8'h83, 0, 1'b0, 0);
      run_mult(8'h07, 8'hFD, 1, 1'b0, 0);
      run_mult(8'h80, 8'h80, 0, 1'b0, 0);
   endtask

   task automatic test_hold();
      run_mult(8'($urandom), 8'($urandom), 5, 1'b1, 0);
   endtask

   task automatic test_reset_mid();
      run_mult(8'h35, 8'hFF, 0, 1'b0, 9);
      run_mult(8'hC9, 8'h5A, 0, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 10; n++)
         run_mult(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 0);
   endtask

   initial begin
      test_reset();
      test_clear_load();
      test_multiply();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
